// File: rtl/uart_tx_arb_pkg.sv
// rtl/uart_tx_arb_pkg.sv - shared FSM states and UART source type codes
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HEADER = 2'd1,
        S_DATA   = 2'd2
    } state_e;

    // Type codes are also decoded by the UART RX demux; keep both sides on these constants.
    localparam logic [6:0] CODE_REMAINING_LAYER = 7'h03;
    localparam logic [6:0] CODE_ETH_FRAME_OUT   = 7'h02;
    localparam logic [6:0] CODE_BRAIN_STATUS    = 7'h05;
    localparam logic [6:0] CODE_PARROT          = 7'h00;

    localparam int HDR_CONT_BIT = 7;

    function automatic logic [6:0] src_code(input int unsigned idx);
        case (idx)
            0:       src_code = CODE_REMAINING_LAYER;
            1:       src_code = CODE_ETH_FRAME_OUT;
            2:       src_code = CODE_BRAIN_STATUS;
            3:       src_code = CODE_PARROT;
            default: src_code = 7'h00;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin pick starting at ptr
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt_onehot,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_valid
);

    localparam int IW = $clog2(N);

    // Scan offsets from farthest to nearest so the closest request to ptr wins.
    always_comb begin
        int k;
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_valid  = 1'b0;
        k          = 0;
        for (int i = N - 1; i >= 0; i--) begin
            k = int'(ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (req[k]) begin
                gnt_onehot    = '0;
                gnt_onehot[k] = 1'b1;
                gnt_idx       = k[IW-1:0];
                gnt_valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin burst framer sharing the UART TX byte stream
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SRC    = 4,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_tdata,
    input  logic [NUM_SRC-1:0]            src_tvalid,
    output logic [NUM_SRC-1:0]            src_tready,
    input  logic [NUM_SRC-1:0]            src_tlast,
    input  logic [NUM_SRC-1:0]            src_enable,
    output logic [DATA_WIDTH-1:0]         uart_out_tdata,
    output logic                          uart_out_tvalid,
    input  logic                          uart_out_tready,
    output logic                          uart_out_tlast,
    output logic                          grant_active,
    output logic [$clog2(NUM_SRC)-1:0]    grant_idx
);

    localparam int IW = $clog2(NUM_SRC);

    logic [1:0]           state_q, state_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]        grant_idx_q, grant_idx_d;
    logic [NUM_SRC-1:0]   grant_oh_q, grant_oh_d;
    logic [7:0]           burst_cnt_q, burst_cnt_d;
    logic [NUM_SRC-1:0]   mid_pkt_q, mid_pkt_d;

    logic [NUM_SRC-1:0]   pick_onehot;
    logic [IW-1:0]        pick_idx;
    logic                 pick_valid;

    logic [DATA_WIDTH-1:0] g_tdata;
    logic                  g_tvalid;
    logic                  g_tlast;
    logic                  burst_end;

    rr_pick #(.N(NUM_SRC)) u_rr_pick (
        .req        (src_tvalid & src_enable),
        .ptr        (rr_ptr_q),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx),
        .gnt_valid  (pick_valid)
    );

    assign g_tdata   = src_tdata[int'(grant_idx_q)*DATA_WIDTH +: DATA_WIDTH];
    assign g_tvalid  = src_tvalid[grant_idx_q];
    assign g_tlast   = src_tlast[grant_idx_q];
    assign burst_end = g_tlast | (burst_cnt_q == 8'(MAX_BURST - 1));

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        grant_idx_d     = grant_idx_q;
        grant_oh_d      = grant_oh_q;
        burst_cnt_d     = burst_cnt_q;
        mid_pkt_d       = mid_pkt_q;
        uart_out_tvalid = 1'b0;
        uart_out_tdata  = '0;
        uart_out_tlast  = 1'b0;
        src_tready      = '0;

        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    grant_idx_d = pick_idx;
                    grant_oh_d  = pick_onehot;
                    rr_ptr_d    = (pick_idx == IW'(NUM_SRC - 1)) ? '0 : pick_idx + IW'(1);
                    state_d     = S_HEADER;
                end
            end
            S_HEADER: begin
                uart_out_tvalid = 1'b1;
                uart_out_tdata  = DATA_WIDTH'({mid_pkt_q[grant_idx_q], src_code(32'(grant_idx_q))});
                if (uart_out_tready) begin
                    burst_cnt_d = '0;
                    state_d     = S_DATA;
                end
            end
            S_DATA: begin
                uart_out_tvalid = g_tvalid;
                uart_out_tdata  = g_tdata;
                uart_out_tlast  = burst_end;
                src_tready      = grant_oh_q & {NUM_SRC{uart_out_tready}};
                if (g_tvalid && uart_out_tready) begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                    if (burst_end) begin
                        // A MAX_BURST cut leaves the packet open; the next header flags continuation.
                        mid_pkt_d[grant_idx_q] = ~g_tlast;
                        state_d                = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            grant_oh_q  <= '0;
            burst_cnt_q <= '0;
            mid_pkt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            grant_oh_q  <= grant_oh_d;
            burst_cnt_q <= burst_cnt_d;
            mid_pkt_q   <= mid_pkt_d;
        end
    end

    assign grant_active = (state_q == S_HEADER) || (state_q == S_DATA);
    assign grant_idx    = grant_idx_q;

endmodule
